imem_bank_power_ctrl: RTL and testbench

- Sequences the power modes of the two 16K-word instruction-memory banks; bank select is addr[14].
- Sits between the fetch requester and the two banks. Drives per-bank chip_sel, standby, sleep and poweroff.
- Idle banks are dropped into standby and then sleep after programmable idle times. Fetches to a non-active bank are stalled until that bank is awake.
- Firmware can force either bank fully off.

---
 rtl/imem_bank_power_ctrl.sv | 141 ++++++++++++++
 tb/tb_imem_bank_power_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/imem_bank_power_ctrl.sv
// Power-mode sequencer for two 16K-word instruction-memory banks.
// Each bank runs an independent ACTIVE/STANDBY/SLEEP/WAKE/OFF machine. Fetches to a
// non-active bank are stalled until it is back in ACTIVE.
module imem_bank_power_ctrl #(
    parameter int unsigned IDLE_STANDBY = 16,
    parameter int unsigned IDLE_SLEEP   = 256,
    parameter int unsigned WAKE_CYCLES  = 4,
    parameter int unsigned CNT_WIDTH    = 9
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [14:0] req_addr,
    input  logic        req_wren,
    output logic        req_ready,
    output logic [1:0]  bank_chip_sel,
    output logic [1:0]  bank_standby,
    output logic [1:0]  bank_sleep,
    output logic [1:0]  bank_poweroff,
    input  logic [1:0]  pwr_off_req,
    output logic [5:0]  bank_state
);

    typedef enum logic [2:0] {
        StActive  = 3'd0,
        StStandby = 3'd1,
        StSleep   = 3'd2,
        StWake    = 3'd3,
        StOff     = 3'd4
    } bank_state_e;

    localparam logic [CNT_WIDTH-1:0] StbyThr  = CNT_WIDTH'(IDLE_STANDBY - 1);
    localparam logic [CNT_WIDTH-1:0] SleepThr = CNT_WIDTH'(IDLE_SLEEP - 1);
    localparam logic [CNT_WIDTH-1:0] IdleMax  = CNT_WIDTH'(IDLE_SLEEP);
    localparam logic [CNT_WIDTH-1:0] WakeInit = CNT_WIDTH'(WAKE_CYCLES - 1);

    bank_state_e          state_q [2];
    bank_state_e          state_d [2];
    logic [CNT_WIDTH-1:0] idle_q  [2];
    logic [CNT_WIDTH-1:0] idle_d  [2];
    logic [CNT_WIDTH-1:0] wake_q  [2];
    logic [CNT_WIDTH-1:0] wake_d  [2];
    logic [1:0]           standby_q, standby_d;
    logic [1:0]           sleep_q, sleep_d;
    logic [1:0]           poweroff_q, poweroff_d;
    logic [1:0]           acc;
    logic                 tgt;

    // Write strobe and in-bank address are passed through to the banks elsewhere.
    logic unused_inputs;
    assign unused_inputs = ^{req_wren, req_addr[13:0]};

    assign tgt = req_addr[14];

    // Combinational accept and chip select; zero latency when the target bank is ACTIVE.
    always_comb begin
        req_ready     = req_valid && (state_q[tgt] == StActive) && !pwr_off_req[tgt];
        bank_chip_sel = 2'b00;
        bank_chip_sel[tgt] = req_ready;
    end

    // Per-bank next state, idle counter and wake counter.
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            acc[b]     = req_valid && (tgt == 1'(b));
            state_d[b] = state_q[b];
            wake_d[b]  = wake_q[b];

            // Idle time is only meaningful while powered and awake.
            if (state_q[b] == StOff || state_q[b] == StWake || acc[b]) begin
                idle_d[b] = '0;
            end else if (idle_q[b] != IdleMax) begin
                idle_d[b] = idle_q[b] + 1'b1;
            end else begin
                idle_d[b] = idle_q[b];
            end

            if (pwr_off_req[b]) begin
                state_d[b] = StOff;
            end else begin
                unique case (state_q[b])
                    StActive: begin
                        if (!acc[b] && idle_q[b] == StbyThr) state_d[b] = StStandby;
                    end
                    StStandby: begin
                        if (acc[b]) state_d[b] = StActive;
                        else if (idle_q[b] == SleepThr) state_d[b] = StSleep;
                    end
                    StSleep: begin
                        if (acc[b]) begin
                            state_d[b] = StWake;
                            wake_d[b]  = WakeInit;
                        end
                    end
                    StWake: begin
                        if (wake_q[b] == '0) state_d[b] = StActive;
                        else wake_d[b] = wake_q[b] - 1'b1;
                    end
                    StOff: begin
                        state_d[b] = StWake;
                        wake_d[b]  = WakeInit;
                    end
                    default: state_d[b] = StActive;
                endcase
            end

            standby_d[b]  = (state_d[b] == StStandby);
            sleep_d[b]    = (state_d[b] == StSleep);
            poweroff_d[b] = (state_d[b] == StOff);
        end
    end

    // State and registered power-control outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int b = 0; b < 2; b++) begin
                state_q[b] <= StActive;
                idle_q[b]  <= '0;
                wake_q[b]  <= '0;
            end
            standby_q  <= '0;
            sleep_q    <= '0;
            poweroff_q <= '0;
        end else begin
            for (int b = 0; b < 2; b++) begin
                state_q[b] <= state_d[b];
                idle_q[b]  <= idle_d[b];
                wake_q[b]  <= wake_d[b];
            end
            standby_q  <= standby_d;
            sleep_q    <= sleep_d;
            poweroff_q <= poweroff_d;
        end
    end

    assign bank_standby  = standby_q;
    assign bank_sleep    = sleep_q;
    assign bank_poweroff = poweroff_q;
    assign bank_state    = {state_q[1], state_q[0]};

endmodule

// File: tb/tb_imem_bank_power_ctrl.sv
// Randomized scoreboard bench for imem_bank_power_ctrl.
// Reference model tracks per bank: powered-off flag, remaining wake cycles and the
// (unbounded) idle time; the mode is derived from those with the idle thresholds.
module tb_imem_bank_power_ctrl;

    localparam int IDLE_STANDBY = 16;
    localparam int IDLE_SLEEP   = 256;
    localparam int WAKE_CYCLES  = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic [14:0] req_addr;
    logic        req_wren;
    logic        req_ready;
    logic [1:0]  bank_chip_sel, bank_standby, bank_sleep, bank_poweroff, pwr_off_req;
    logic [5:0]  bank_state;

    imem_bank_power_ctrl #(
        .IDLE_STANDBY(IDLE_STANDBY),
        .IDLE_SLEEP  (IDLE_SLEEP),
        .WAKE_CYCLES (WAKE_CYCLES),
        .CNT_WIDTH   (9)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_addr     (req_addr),
        .req_wren     (req_wren),
        .req_ready    (req_ready),
        .bank_chip_sel(bank_chip_sel),
        .bank_standby (bank_standby),
        .bank_sleep   (bank_sleep),
        .bank_poweroff(bank_poweroff),
        .pwr_off_req  (pwr_off_req),
        .bank_state   (bank_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       ready;
        logic [1:0] cs, sb, sl, po;
        logic [5:0] st;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_err    = 0;

    // Reference model state
    bit   m_off  [2];
    int   m_wake [2];
    int   m_idle [2];
    logic last_ready;

    // Mode codes: 0 ACTIVE, 1 STANDBY, 2 SLEEP, 3 WAKE, 4 OFF
    function automatic int mode(int b);
        if (m_off[b]) return 4;
        if (m_wake[b] > 0) return 3;
        if (m_idle[b] < IDLE_STANDBY) return 0;
        if (m_idle[b] < IDLE_SLEEP) return 1;
        return 2;
    endfunction

    function automatic void model_step(bit rst, bit v, bit t, logic [1:0] pwr);
        for (int b = 0; b < 2; b++) begin
            int  m;
            bit  a;
            m = mode(b);
            a = v && (int'(t) == b);
            if (rst) begin
                m_off[b] = 0; m_wake[b] = 0; m_idle[b] = 0;
            end else if (pwr[b]) begin
                m_off[b] = 1; m_wake[b] = 0; m_idle[b] = 0;
            end else if (m_off[b]) begin
                m_off[b] = 0; m_wake[b] = WAKE_CYCLES; m_idle[b] = 0;
            end else if (m_wake[b] > 0) begin
                m_wake[b]--; m_idle[b] = 0;
            end else if (m == 2 && a) begin
                m_wake[b] = WAKE_CYCLES; m_idle[b] = 0;
            end else if (a) begin
                m_idle[b] = 0;
            end else if (m_idle[b] < IDLE_SLEEP) begin
                m_idle[b]++;
            end
        end
    endfunction

    function automatic exp_t model_out(bit v, bit t, logic [1:0] pwr);
        exp_t e;
        int   m0, m1, mt;
        m0 = mode(0);
        m1 = mode(1);
        mt = t ? m1 : m0;
        e.ready = v && (mt == 0) && !pwr[t];
        e.cs    = 2'b00;
        if (e.ready) e.cs = t ? 2'b10 : 2'b01;
        e.sb = {m1 == 1, m0 == 1};
        e.sl = {m1 == 2, m0 == 2};
        e.po = {m1 == 4, m0 == 4};
        e.st = {3'(m1), 3'(m0)};
        return e;
    endfunction

    // Drive next-cycle inputs honouring the hold-until-ready rule, then queue the expectation.
    task automatic drive_cycle(int p, int bank_mode, int pwr_rate);
        exp_t e;
        bit   waking;
        waking = (m_wake[0] > 0) || (m_wake[1] > 0);
        reset = ($urandom_range(0, 1999) == 0) || (waking && $urandom_range(0, 49) == 0);
        if (!(req_valid && !last_ready)) begin
            req_valid = ($urandom_range(0, 99) < p);
            req_addr  = 15'($urandom);
            req_wren  = 1'($urandom);
            if (bank_mode == 0) req_addr[14] = 1'b0;
            else if (bank_mode == 1) req_addr[14] = 1'b1;
        end
        for (int b = 0; b < 2; b++) begin
            if (pwr_rate == 0) pwr_off_req[b] = 1'b0;
            else if ($urandom_range(0, 999) < pwr_rate) pwr_off_req[b] = ~pwr_off_req[b];
        end
        e = model_out(req_valid, req_addr[14], pwr_off_req);
        last_ready = e.ready;
        exp_q.push_back(e);
    endtask

    task automatic chk(string name, logic [5:0] act, logic [5:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare DUT outputs against queued expectations mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("req_ready", 6'(req_ready), 6'(e.ready));
                chk("chip_sel", 6'(bank_chip_sel), 6'(e.cs));
                chk("standby", 6'(bank_standby), 6'(e.sb));
                chk("sleep", 6'(bank_sleep), 6'(e.sl));
                chk("poweroff", 6'(bank_poweroff), 6'(e.po));
                chk("bank_state", bank_state, e.st);
            end
        end
    end

    // Phases: request probability %, length, bank select mode (0/1 fixed, 2 random),
    // pwr_off toggle rate per mille.
    int ph_p   [$] = '{100, 0, 100, 0, 100, 100, 0, 60};
    int ph_len [$] = '{20, 300, 30, 20, 40, 200, 300, 200};
    int ph_bank[$] = '{0, 2, 2, 2, 1, 0, 2, 2};
    int ph_pwr [$] = '{0, 0, 0, 0, 0, 25, 0, 30};

    initial begin
        int opts_p[4];
        opts_p = '{0, 3, 30, 100};
        for (int i = 0; i < 24; i++) begin
            ph_p.push_back(opts_p[$urandom_range(0, 3)]);
            ph_len.push_back(int'($urandom_range(20, 400)));
            ph_bank.push_back(int'($urandom_range(0, 2)));
            ph_pwr.push_back(($urandom_range(0, 2) == 0) ? 20 : 0);
        end

        reset       = 1'b1;
        req_valid   = 1'b0;
        req_addr    = '0;
        req_wren    = 1'b0;
        pwr_off_req = 2'b00;
        last_ready  = 1'b0;
        @(posedge clk);
        model_step(1'b1, 1'b0, 1'b0, 2'b00);
        #1;
        reset = 1'b0;
        begin
            exp_t e;
            e = model_out(1'b0, 1'b0, 2'b00);
            last_ready = e.ready;
            exp_q.push_back(e);
        end

        for (int ph = 0; ph < ph_p.size(); ph++) begin
            for (int c = 0; c < ph_len[ph]; c++) begin
                @(posedge clk);
                model_step(reset, req_valid, req_addr[14], pwr_off_req);
                #1;
                drive_cycle(ph_p[ph], ph_bank[ph], ph_pwr[ph]);
            end
        end

        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
